// File: rtl/axi_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | axi_pkg : shared AXI4 read/write responder encodings and state type    |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
package axi_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  localparam logic [2:0] AXI_SIZE_8B     = 3'b011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2
  } responder_state_t;

  // WRAP bursts are only defined for 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_legal(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_burst_addr_gen.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | axi_burst_addr_gen : combinational next-beat address for 8-byte beats  |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
module axi_burst_addr_gen
  import axi_pkg::*;
(
  input  logic [63:0] i_addr,
  input  logic [7:0]  i_len,
  input  logic [1:0]  i_burst,
  output logic [63:0] o_next_addr,
  output logic        o_wrap_legal
);

  logic [63:0] w_incr;
  logic [63:0] w_mask;

  always_comb begin
    w_incr       = i_addr + 64'd8;
    w_mask       = (({56'd0, i_len} + 64'd1) << 3) - 64'd1;
    o_wrap_legal = wrap_len_legal(i_len);
    // Illegal WRAP lengths and the reserved burst type fall back to INCR.
    o_next_addr  = w_incr;
    if (i_burst == AXI_BURST_FIXED) begin
      o_next_addr = i_addr;
    end else if ((i_burst == AXI_BURST_WRAP) && o_wrap_legal) begin
      o_next_addr = (i_addr & ~w_mask) | (w_incr & w_mask);
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi_read_responder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | axi_read_responder : AXI4 64-bit read responder over a backing memory  |
// | Optional macro RESP_STALL_EN inserts an rvalid bubble per STALL_PERIOD |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
module axi_read_responder
  import axi_pkg::*;
#(
  parameter int MEM_WORDS    = 4096,
  parameter int READ_LATENCY = 2,
  parameter int STALL_PERIOD = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  input  logic [63:0] s_axi_araddr,
  input  logic [7:0]  s_axi_arlen,
  input  logic [2:0]  s_axi_arsize,
  input  logic [1:0]  s_axi_arburst,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic [63:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rlast,
  input  logic        init_we,
  input  logic [63:0] init_addr,
  input  logic [63:0] init_data,
  output logic        busy
);

  localparam int c_idx_w = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int c_lat_w = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  if ((STALL_PERIOD < 1) || (STALL_PERIOD > 256)) begin : g_bad_stall_period
    $error("axi_read_responder: STALL_PERIOD must be in 1..256");
  end

  logic [63:0] mem [MEM_WORDS];

  responder_state_t     state_q, state_d;
  logic [63:0]          addr_q, addr_d;
  logic [7:0]           len_q, len_d;
  logic [7:0]           beat_q, beat_d;
  logic [1:0]           burst_q, burst_d;
  logic [2:0]           size_q, size_d;
  logic [c_lat_w-1:0]   lat_q, lat_d;
  logic                 arready_q, arready_d;
  logic [63:0]          rdata_q, rdata_d;
  logic [1:0]           rresp_q, rresp_d;

  logic                 w_bubble;
  logic                 w_rvalid, w_last, w_ar_hs, w_r_hs;
  logic [63:0]          w_cur_addr, w_next_addr, w_rd_addr, w_rd_word;
  logic [7:0]           w_cur_len;
  logic [1:0]           w_cur_burst;
  logic [2:0]           w_cur_size;
  logic                 w_wrap_legal, w_burst_err;
  logic                 w_rd_oor, w_init_oor, w_mem_we;
  logic [c_idx_w-1:0]   w_rd_idx, w_init_idx;
  logic [63:0]          w_cap_data;
  logic [1:0]           w_cap_resp;
  logic                 w_unused_init_lsbs;

`ifdef RESP_STALL_EN
  logic                 bubble_q, bubble_d;
  logic [7:0]           stall_q, stall_d;
  assign w_bubble = bubble_q;
`else
  assign w_bubble = 1'b0;
`endif

  assign w_unused_init_lsbs = ^init_addr[2:0];

  // In IDLE the request is still on the bus, afterwards it lives in the latches.
  always_comb begin
    w_cur_addr  = (state_q == IDLE) ? s_axi_araddr  : addr_q;
    w_cur_len   = (state_q == IDLE) ? s_axi_arlen   : len_q;
    w_cur_burst = (state_q == IDLE) ? s_axi_arburst : burst_q;
    w_cur_size  = (state_q == IDLE) ? s_axi_arsize  : size_q;
  end

  axi_burst_addr_gen u_addr_gen (
    .i_addr       (w_cur_addr),
    .i_len        (w_cur_len),
    .i_burst      (w_cur_burst),
    .o_next_addr  (w_next_addr),
    .o_wrap_legal (w_wrap_legal)
  );

  always_comb begin
    w_rvalid    = (state_q == BURST) && !w_bubble;
    w_last      = (beat_q == len_q);
    w_ar_hs     = arready_q && s_axi_arvalid;
    w_r_hs      = w_rvalid && s_axi_rready;
    w_burst_err = (w_cur_size != AXI_SIZE_8B) || (w_cur_burst == 2'b11) ||
                  ((w_cur_burst == AXI_BURST_WRAP) && !w_wrap_legal);

    w_init_oor  = init_addr[63:3] >= 61'(MEM_WORDS);
    w_init_idx  = init_addr[3 +: c_idx_w];
    w_mem_we    = init_we && (state_q == IDLE) && !w_init_oor && !reset;

    w_rd_addr   = (state_q == BURST) ? w_next_addr : w_cur_addr;
    w_rd_oor    = w_rd_addr[63:3] >= 61'(MEM_WORDS);
    w_rd_idx    = w_rd_addr[3 +: c_idx_w];
    // Forward a same-cycle backdoor write so beat 0 sees the new word.
    w_rd_word   = (w_mem_we && (w_init_idx == w_rd_idx)) ? init_data : mem[w_rd_idx];
    w_cap_data  = w_rd_oor ? 64'd0 : w_rd_word;
    w_cap_resp  = (w_burst_err || w_rd_oor) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    burst_d   = burst_q;
    size_d    = size_q;
    beat_d    = beat_q;
    lat_d     = lat_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    arready_d = 1'b0;
`ifdef RESP_STALL_EN
    bubble_d  = 1'b0;
    stall_d   = stall_q;
`endif
    case (state_q)
      IDLE: begin
        arready_d = 1'b1;
        if (w_ar_hs) begin
          addr_d    = s_axi_araddr;
          len_d     = s_axi_arlen;
          burst_d   = s_axi_arburst;
          size_d    = s_axi_arsize;
          beat_d    = 8'd0;
          arready_d = 1'b0;
`ifdef RESP_STALL_EN
          stall_d   = 8'd0;
`endif
          if (READ_LATENCY == 0) begin
            rdata_d = w_cap_data;
            rresp_d = w_cap_resp;
            state_d = BURST;
          end else begin
            lat_d   = c_lat_w'(READ_LATENCY - 1);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (lat_q == '0) begin
          rdata_d = w_cap_data;
          rresp_d = w_cap_resp;
          state_d = BURST;
        end else begin
          lat_d = lat_q - c_lat_w'(1);
        end
      end
      BURST: begin
        if (w_r_hs) begin
          if (w_last) begin
            state_d   = IDLE;
            arready_d = 1'b1;
          end else begin
            addr_d  = w_next_addr;
            beat_d  = beat_q + 8'd1;
            rdata_d = w_cap_data;
            rresp_d = w_cap_resp;
`ifdef RESP_STALL_EN
            if (stall_q == 8'(STALL_PERIOD - 1)) begin
              bubble_d = 1'b1;
              stall_d  = 8'd0;
            end else begin
              stall_d  = stall_q + 8'd1;
            end
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= 64'd0;
      len_q     <= 8'd0;
      beat_q    <= 8'd0;
      burst_q   <= AXI_BURST_INCR;
      size_q    <= AXI_SIZE_8B;
      lat_q     <= '0;
      arready_q <= 1'b0;
      rdata_q   <= 64'd0;
      rresp_q   <= AXI_RESP_OKAY;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      burst_q   <= burst_d;
      size_q    <= size_d;
      lat_q     <= lat_d;
      arready_q <= arready_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

`ifdef RESP_STALL_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_q <= 1'b0;
      stall_q  <= 8'd0;
    end else begin
      bubble_q <= bubble_d;
      stall_q  <= stall_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      mem[w_init_idx] <= init_data;
    end
  end

  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = w_rvalid;
  assign s_axi_rlast   = w_rvalid && w_last;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign busy          = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_axi_read_responder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_axi_read_responder : scoreboard bench for axi_read_responder        |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
module tb_axi_read_responder;
  import axi_pkg::*;

  localparam int MEM_WORDS    = 4096;
  localparam int STALL_PERIOD = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_axi_arvalid, s_axi_arready;
  logic [63:0] s_axi_araddr;
  logic [7:0]  s_axi_arlen;
  logic [2:0]  s_axi_arsize;
  logic [1:0]  s_axi_arburst;
  logic        s_axi_rvalid, s_axi_rready, s_axi_rlast;
  logic [63:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        init_we;
  logic [63:0] init_addr, init_data;
  logic        busy;

  always #5 clk = ~clk;

  axi_read_responder #(
    .MEM_WORDS(MEM_WORDS), .READ_LATENCY(2), .STALL_PERIOD(STALL_PERIOD)
  ) dut (
    .clk(clk), .reset(reset),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
    .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
    .busy(busy)
  );

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  beat_t       sb[$];
  logic [63:0] mdl [int];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          stalled_prev = 0;
  beat_t       held;
  int          stall_cycles = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Independent reference for the beat sequence of one burst.
  task automatic push_burst(input logic [63:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [2:0] size);
    logic [63:0]     a;
    longint unsigned idx, bound, off;
    bit              wrap_ok, err;
    beat_t           b;
    a       = addr;
    wrap_ok = (burst == 2'b10) && (len == 1 || len == 3 || len == 7 || len == 15);
    err     = (size != 3'b011) || (burst == 2'b11) || ((burst == 2'b10) && !wrap_ok);
    bound   = (longint'(len) + 1) * 8;
    for (int i = 0; i <= int'(len); i++) begin
      idx = a >> 3;
      if (idx >= MEM_WORDS) begin
        b.data = 64'd0;
        b.resp = 2'b10;
      end else begin
        b.data = mdl.exists(int'(idx)) ? mdl[int'(idx)] : 64'd0;
        b.resp = err ? 2'b10 : 2'b00;
      end
      b.last = (i == int'(len));
      sb.push_back(b);
      if (burst == 2'b00) begin
        a = a;
      end else if (wrap_ok) begin
        off = a % bound;
        a   = a - off + ((off + 8) % bound);
      end else begin
        a = a + 64'd8;
      end
    end
  endtask

  task automatic bd_write(input logic [63:0] addr, input logic [63:0] data);
    init_we   = 1'b1;
    init_addr = addr;
    init_data = data;
    @(posedge clk); #1;
    init_we   = 1'b0;
    if ((addr >> 3) < MEM_WORDS) mdl[int'(addr >> 3)] = data;
  endtask

  task automatic do_ar(input logic [63:0] addr, input logic [7:0] len,
                       input logic [1:0] burst, input logic [2:0] size);
    bit done = 0;
    push_burst(addr, len, burst, size);
    s_axi_arvalid = 1'b1;
    s_axi_araddr  = addr;
    s_axi_arlen   = len;
    s_axi_arburst = burst;
    s_axi_arsize  = size;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (s_axi_arready) begin
        @(posedge clk); #1;
        done = 1;
      end
    end
    s_axi_arvalid = 1'b0;
    chk("ar_handshake", 64'(done), 64'd1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, 64'(sb.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (!reset && s_axi_rvalid) begin
      if (stalled_prev) begin
        chk("hold_rdata", s_axi_rdata, held.data);
        chk("hold_rresp", 64'(s_axi_rresp), 64'(held.resp));
        chk("hold_rlast", 64'(s_axi_rlast), 64'(held.last));
      end
      stalled_prev = !s_axi_rready;
      held         = '{data: s_axi_rdata, resp: s_axi_rresp, last: s_axi_rlast};
      if (!s_axi_rready) stall_cycles++;
      if (s_axi_rready) begin
        if (sb.size() == 0) begin
          chk("unexpected_beat", 64'(sb.size()), 64'd1);
        end else begin
          beat_t e;
          e = sb.pop_front();
          chk("rdata", s_axi_rdata, e.data);
          chk("rresp", 64'(s_axi_rresp), 64'(e.resp));
          chk("rlast", 64'(s_axi_rlast), 64'(e.last));
        end
      end
    end else begin
      stalled_prev = 0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, cyc, n;
    reset = 1'b1; s_axi_arvalid = 1'b0; s_axi_araddr = '0; s_axi_arlen = '0;
    s_axi_arsize = 3'b011; s_axi_arburst = 2'b01; s_axi_rready = 1'b1;
    init_we = 1'b0; init_addr = '0; init_data = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_arready", 64'(s_axi_arready), 64'd0);
    chk("rst_rvalid",  64'(s_axi_rvalid),  64'd0);
    chk("rst_rlast",   64'(s_axi_rlast),   64'd0);
    chk("rst_rdata",   s_axi_rdata,        64'd0);
    chk("rst_rresp",   64'(s_axi_rresp),   64'd0);
    chk("rst_busy",    64'(busy),          64'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("idle_arready", 64'(s_axi_arready), 64'd1);
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) bd_write(64'(i * 8), 64'h1000 + 64'(i));
    bd_write(64'((MEM_WORDS - 1) * 8), 64'hFFF0_0000_0000_0ABC);
    bd_write(64'(MEM_WORDS * 8), 64'h0BAD);

    // INCR len 7: latency, busy, dropped backdoor write, beat spacing.
    do_ar(64'h0, 8'd7, AXI_BURST_INCR, 3'b011);
    init_we = 1'b1; init_addr = 64'h0; init_data = 64'hDEAD;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (s_axi_rvalid) break;
    end
    init_we = 1'b0;
    chk("first_rvalid_latency", 64'(lat), 64'd3);
    chk("busy_in_burst", 64'(busy), 64'd1);
    cyc = 1;
    while (!(s_axi_rvalid && s_axi_rlast) && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
`ifdef RESP_STALL_EN
    chk("burst_cycles", 64'(cyc), 64'd9);
`else
    chk("burst_cycles", 64'(cyc), 64'd8);
`endif
    wait_done("incr8_done");

    do_ar(64'h18, 8'd3, AXI_BURST_WRAP, 3'b011);
    wait_done("wrap4_done");

    // Hold rready low for three cycles while beat 2 is presented.
    stall_cycles = 0;
    do_ar(64'h0, 8'd3, AXI_BURST_INCR, 3'b011);
    n = 0;
    while (sb.size() != 2 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1 s_axi_rready = 1'b0;
    repeat (3) @(posedge clk);
    #1 s_axi_rready = 1'b1;
    wait_done("stall_done");
    chk("stall_cycles", 64'(stall_cycles), 64'd3);

    do_ar(64'((MEM_WORDS - 1) * 8), 8'd1, AXI_BURST_INCR, 3'b011);
    wait_done("oor_done");

    // Reset during beat 1 of a long burst.
    do_ar(64'h0, 8'd7, AXI_BURST_INCR, 3'b011);
    n = 0;
    while (sb.size() != 7 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1 reset = 1'b1;
    sb.delete();
    @(posedge clk); @(negedge clk);
    chk("rst_mid_rvalid",  64'(s_axi_rvalid),  64'd0);
    chk("rst_mid_arready", 64'(s_axi_arready), 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("post_rst_busy",    64'(busy),          64'd0);
    chk("post_rst_arready", 64'(s_axi_arready), 64'd1);
    @(posedge clk); #1;
    do_ar(64'h28, 8'd0, AXI_BURST_INCR, 3'b011);
    wait_done("single_done");

    do_ar(64'h0, 8'd0, AXI_BURST_INCR, 3'b011);
    wait_done("dropped_write_done");

    do_ar(64'h10, 8'd2, AXI_BURST_FIXED, 3'b011);
    wait_done("fixed_done");

    do_ar(64'h20, 8'd1, AXI_BURST_INCR, 3'b010);
    wait_done("bad_size_done");

    do_ar(64'h8, 8'd2, AXI_BURST_WRAP, 3'b011);
    wait_done("bad_wrap_done");

    do_ar(64'h30, 8'd1, 2'b11, 3'b011);
    wait_done("reserved_burst_done");

    // Backdoor write in the same cycle as the AR handshake.
    init_we = 1'b1; init_addr = 64'h30; init_data = 64'hBEEF;
    mdl[6] = 64'hBEEF;
    do_ar(64'h30, 8'd0, AXI_BURST_INCR, 3'b011);
    init_we = 1'b0;
    wait_done("fwd_done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
